svf_objection_ctrl: RTL

- Hardware-side end-of-test controller. It is the responder to the test-start/test-end handshake that the SVF root drives.
- Tracks raise/drop objections from up to N bench agents.
- Once a test starts and every objection has been dropped, waits a drain window, then requests test end from the root with a status code.
- Holds the request until the root acknowledges it.

---
 rtl/svf_objection_pkg.sv | 20 ++
 rtl/svf_popcount.sv | 17 +
 rtl/svf_objection_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/svf_objection_pkg.sv
// Shared types for the end-of-test objection controller.
package svf_objection_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ACTIVE,
        DRAIN,
        END_REQ,
        DONE
    } svf_obj_state_e;

    typedef enum logic [1:0] {
        PASS         = 2'd0,
        UNDERFLOW    = 2'd1,
        TIMEOUT      = 2'd2,
        NO_OBJECTION = 2'd3
    } svf_obj_status_e;

endpackage

// File: rtl/svf_popcount.sv
// Combinational population count of a W-bit vector.
module svf_popcount #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/svf_objection_ctrl.sv
// End-of-test controller: counts raise/drop objections, drains, then requests test end.
// Optional watchdog enabled by defining SVF_OBJ_TIMEOUT_EN.
module svf_objection_ctrl
    import svf_objection_pkg::*;
#(
    parameter int N_SRC          = 4,
    parameter int COUNT_W        = 8,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               test_start,
    input  logic [N_SRC-1:0]   raise,
    input  logic [N_SRC-1:0]   drop,
    input  logic               end_ack,
    output logic               end_req,
    output logic [1:0]         end_status,
    output logic [COUNT_W-1:0] obj_count,
    output logic               busy
);

    localparam int PCW = $clog2(N_SRC + 1);
    localparam int SW  = COUNT_W + 5;
    localparam int DW  = $clog2(DRAIN_CYCLES + 1);
    localparam logic signed [SW-1:0] CNT_MAX = {5'b0, {COUNT_W{1'b1}}};

    svf_obj_state_e        state;
    svf_obj_status_e       status_q;
    logic [DW-1:0]         drain_cnt;
    logic                  uf_flag;
    logic [PCW-1:0]        pc_raise;
    logic [PCW-1:0]        pc_drop;
    logic signed [SW-1:0]  next_s;
    logic [COUNT_W-1:0]    next_cnt;
    logic                  uf_now;
    logic                  next_pos;
    logic                  drain_done;
    logic                  counting;
    logic                  wd_hit;

    svf_popcount #(.W(N_SRC)) u_pc_raise (.bits(raise), .count(pc_raise));
    svf_popcount #(.W(N_SRC)) u_pc_drop  (.bits(drop),  .count(pc_drop));

    // Same-bit raise+drop cancels naturally in the signed sum.
    always_comb begin
        next_s   = $signed({5'b0, obj_count}) + $signed(SW'(pc_raise)) - $signed(SW'(pc_drop));
        uf_now   = 1'b0;
        next_cnt = next_s[COUNT_W-1:0];
        if (next_s < 0) begin
            uf_now   = 1'b1;
            next_cnt = '0;
        end else if (next_s > CNT_MAX) begin
            next_cnt = '1;
        end
    end

    assign next_pos   = (next_cnt != '0);
    assign drain_done = (drain_cnt == DW'(DRAIN_CYCLES));
    assign counting   = (state == RUN) || (state == ACTIVE) || (state == DRAIN);
    assign end_status = status_q;

`ifdef SVF_OBJ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    assign wd_hit = counting && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle so every test starts with a fresh budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == IDLE || state == DONE) begin
            wd_cnt <= '0;
        end else if (counting) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            status_q  <= PASS;
            end_req   <= 1'b0;
            obj_count <= '0;
            busy      <= 1'b0;
            drain_cnt <= '0;
            uf_flag   <= 1'b0;
        end else begin
            if (counting) begin
                obj_count <= next_cnt;
                if (uf_now) uf_flag <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (test_start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        obj_count <= '0;
                        drain_cnt <= '0;
                        uf_flag   <= 1'b0;
                        status_q  <= PASS;
                    end
                end
                RUN: begin
                    if (wd_hit) begin
                        state    <= END_REQ;
                        end_req  <= 1'b1;
                        status_q <= TIMEOUT;
                    end else if (next_pos) begin
                        state     <= ACTIVE;
                        drain_cnt <= '0;
                    end else if (drain_done) begin
                        state    <= END_REQ;
                        end_req  <= 1'b1;
                        status_q <= NO_OBJECTION;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (wd_hit) begin
                        state    <= END_REQ;
                        end_req  <= 1'b1;
                        status_q <= TIMEOUT;
                    end else if (!next_pos) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (wd_hit) begin
                        state    <= END_REQ;
                        end_req  <= 1'b1;
                        status_q <= TIMEOUT;
                    end else if (next_pos) begin
                        state     <= ACTIVE;
                        drain_cnt <= '0;
                    end else if (drain_done) begin
                        state    <= END_REQ;
                        end_req  <= 1'b1;
                        status_q <= (uf_flag || uf_now) ? UNDERFLOW : PASS;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                END_REQ: begin
                    // end_req is held until the root acknowledges it.
                    if (end_ack) begin
                        state   <= DONE;
                        end_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    end_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
